matmul_rect_top: RTL and testbench

- Parametrised successor to the fixed 8x8 matrix multiplier: computes C = A x B for runtime-selectable rectangular dims M x K times K x N, each up to MAX_DIM.
- Signed operands; wide internal accumulator; result stored at DATA_WIDTH.
- Owns three single-port-per-side BRAMs: A and B written by the host, C read by the host. Driven by a start/done handshake from the host or testbench.

---
 rtl/matmul_rect_top.sv | 217 +++++++++++++++++++++
 tb/tb_matmul_rect_top.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_rect_top.sv
// Rectangular matrix multiplier C[MxN] = A[MxK] * B[KxN] with on-chip A/B/C BRAMs.
// Signed operands, wide accumulator, result stored at DATA_WIDTH.
// Optional build macro MATMUL_SAT_EN: saturate (instead of wrap) the stored result
// and report clipping on sat_flag.
module matmul_rect_top #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_DIM    = 16,
  parameter int unsigned DIM_W      = $clog2(MAX_DIM),
  parameter int unsigned ADDR_WIDTH = 2 * DIM_W,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + DIM_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_W-1:0]      m_dim_m1,
  input  logic [DIM_W-1:0]      k_dim_m1,
  input  logic [DIM_W-1:0]      n_dim_m1,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  input  logic [DATA_WIDTH-1:0] a_wr_din,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic                  a_wr_en,
  input  logic [DATA_WIDTH-1:0] b_wr_din,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic                  b_wr_en,
  input  logic [ADDR_WIDTH-1:0] c_rd_addr,
  output logic [DATA_WIDTH-1:0] c_rd_dout
);

  localparam int unsigned PROD_W    = 2 * DATA_WIDTH;
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [DIM_W-1:0] i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic             drain_q, drain_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic [DATA_WIDTH-1:0] c_rd_dout_q, c_rd_dout_d;

  logic [DATA_WIDTH-1:0] a_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] c_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;

  logic [ADDR_WIDTH-1:0] a_rd_addr_c, b_rd_addr_c, c_wr_addr_c;
  logic signed [PROD_W-1:0] a_ext_c, b_ext_c;
  logic [DATA_WIDTH-1:0] conv_c;
  logic                  sat_hit_c;
  logic                  c_we_c;

  // Row-major address with a fixed stride of MAX_DIM.
  function automatic logic [ADDR_WIDTH-1:0] rc_addr(input logic [DIM_W-1:0] r,
                                                   input logic [DIM_W-1:0] c);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(c);
  endfunction

  assign a_rd_addr_c = rc_addr(i_q, kk_q);
  assign b_rd_addr_c = rc_addr(kk_q, j_q);
  assign c_wr_addr_c = rc_addr(i_q, j_q);
  assign a_ext_c     = PROD_W'($signed(a_rd_q));
  assign b_ext_c     = PROD_W'($signed(b_rd_q));

  // A/B BRAMs: host write port (blocked while busy) and engine read port.
  always_ff @(posedge clock) begin
    if (a_wr_en && !busy_q) a_mem[a_wr_addr] <= a_wr_din;
    if (b_wr_en && !busy_q) b_mem[b_wr_addr] <= b_wr_din;
    a_rd_q <= a_mem[a_rd_addr_c];
    b_rd_q <= b_mem[b_rd_addr_c];
  end

  // C BRAM: engine write port.
  always_ff @(posedge clock) begin
    if (c_we_c) c_mem[c_wr_addr_c] <= conv_c;
  end

  // Accumulator to stored-width conversion: wrap by default, clip when enabled.
  always_comb begin
    conv_c    = acc_q[DATA_WIDTH-1:0];
    sat_hit_c = 1'b0;
`ifdef MATMUL_SAT_EN
    if (!((&acc_q[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc_q[ACC_WIDTH-1:DATA_WIDTH-1]))) begin
      sat_hit_c = 1'b1;
      conv_c    = acc_q[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`endif
  end

  // State, counters and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      kk_q        <= '0;
      drain_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      c_rd_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      k_q         <= k_d;
      n_q         <= n_d;
      i_q         <= i_d;
      j_q         <= j_d;
      kk_q        <= kk_d;
      drain_q     <= drain_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      c_rd_dout_q <= c_rd_dout_d;
    end
  end

  // Next-state, counter sequencing and read/multiply/accumulate pipeline.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    k_d         = k_q;
    n_d         = n_q;
    i_d         = i_q;
    j_d         = j_q;
    kk_d        = kk_q;
    drain_d     = drain_q;
    busy_d      = busy_q;
    done_d      = done_q;
    sat_d       = sat_q;
    c_we_c      = 1'b0;
    v1_d        = (state_q == S_READ);
    v2_d        = v1_q;
    prod_d      = a_ext_c * b_ext_c;
    acc_d       = v2_q ? acc_q + ACC_WIDTH'(prod_q) : acc_q;
    c_rd_dout_d = c_mem[c_rd_addr];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = m_dim_m1;
          k_d     = k_dim_m1;
          n_d     = n_dim_m1;
          i_d     = '0;
          j_d     = '0;
          kk_d    = '0;
          acc_d   = '0;
          done_d  = 1'b0;
          sat_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (kk_q == k_q) begin
          kk_d    = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          kk_d = kk_q + DIM_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_WRITE;
        else         drain_d = 1'b1;
      end
      S_WRITE: begin
        c_we_c = 1'b1;
        acc_d  = '0;
        sat_d  = sat_q | sat_hit_c;
        if (j_q == n_q) begin
          j_d = '0;
          if (i_q == m_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + DIM_W'(1);
            state_d = S_READ;
          end
        end else begin
          j_d     = j_q + DIM_W'(1);
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sat_flag  = sat_q;
  assign c_rd_dout = c_rd_dout_q;

endmodule

// File: tb/tb_matmul_rect_top.sv
// Self-checking bench for matmul_rect_top: directed and randomized runs compared
// against an arithmetic reference model of the three matrices.
module tb_matmul_rect_top;

  localparam int MD = 16;

  logic        clock, reset, start;
  logic [3:0]  m_dim_m1, k_dim_m1, n_dim_m1;
  logic        busy, done, sat_flag;
  logic [31:0] a_wr_din, b_wr_din, c_rd_dout;
  logic [7:0]  a_wr_addr, b_wr_addr, c_rd_addr;
  logic        a_wr_en, b_wr_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_m [MD*MD];
  logic [31:0] b_m [MD*MD];
  logic [31:0] c_m [MD*MD];
  logic        sat_m;

  matmul_rect_top dut (
    .clock(clock), .reset(reset), .start(start),
    .m_dim_m1(m_dim_m1), .k_dim_m1(k_dim_m1), .n_dim_m1(n_dim_m1),
    .busy(busy), .done(done), .sat_flag(sat_flag),
    .a_wr_din(a_wr_din), .a_wr_addr(a_wr_addr), .a_wr_en(a_wr_en),
    .b_wr_din(b_wr_din), .b_wr_addr(b_wr_addr), .b_wr_en(b_wr_en),
    .c_rd_addr(c_rd_addr), .c_rd_dout(c_rd_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed dot products, then wrap or clip to 32 bits.
  function automatic void model_run(input int m, input int k, input int n);
    logic signed [71:0] s, p;
    sat_m = 1'b0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = '0;
        for (int x = 0; x < k; x++) begin
          p = 72'($signed(a_m[r*MD+x])) * 72'($signed(b_m[x*MD+c]));
          s = s + p;
        end
`ifdef MATMUL_SAT_EN
        if (s > 72'sd2147483647) begin
          c_m[r*MD+c] = 32'h7FFFFFFF; sat_m = 1'b1;
        end else if (s < -72'sd2147483648) begin
          c_m[r*MD+c] = 32'h80000000; sat_m = 1'b1;
        end else begin
          c_m[r*MD+c] = s[31:0];
        end
`else
        c_m[r*MD+c] = s[31:0];
`endif
      end
    end
  endfunction

  task automatic wr_a(input int r, input int c, input logic [31:0] v);
    @(negedge clock);
    a_wr_addr = 8'(r*MD+c); a_wr_din = v; a_wr_en = 1'b1;
    @(negedge clock);
    a_wr_en = 1'b0;
    a_m[r*MD+c] = v;
  endtask

  task automatic wr_b(input int r, input int c, input logic [31:0] v);
    @(negedge clock);
    b_wr_addr = 8'(r*MD+c); b_wr_din = v; b_wr_en = 1'b1;
    @(negedge clock);
    b_wr_en = 1'b0;
    b_m[r*MD+c] = v;
  endtask

  task automatic rd_c(input int r, input int c, output logic [31:0] v);
    @(negedge clock);
    c_rd_addr = 8'(r*MD+c);
    @(negedge clock);
    v = c_rd_dout;
  endtask

  task automatic check_c(input int m, input int n);
    logic [31:0] v;
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        rd_c(r, c, v);
        check($sformatf("C[%0d][%0d]", r, c), 64'(v), 64'(c_m[r*MD+c]));
      end
  endtask

  // mode 0: plain run; 1: inject start + A write mid-run; 2: reset at cycle 100.
  task automatic run(input int m, input int k, input int n, input int mode,
                     output int cnt, output int bcnt);
    bit aborted;
    aborted = 1'b0;
    @(negedge clock);
    m_dim_m1 = 4'(m-1); k_dim_m1 = 4'(k-1); n_dim_m1 = 4'(n-1);
    start = 1'b1;
    cnt = 0; bcnt = 0;
    do begin
      @(posedge clock);
      cnt++;
      @(negedge clock);
      start = 1'b0; a_wr_en = 1'b0;
      if (busy) bcnt++;
      if (mode == 1 && cnt == 50) begin
        start = 1'b1; a_wr_addr = 8'd0; a_wr_din = 32'd99; a_wr_en = 1'b1;
      end
      if (mode == 2 && cnt == 100) begin
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_dout", 64'(c_rd_dout), 64'd0);
        aborted = 1'b1;
      end
    end while (!done && !aborted && cnt < 20000);
  endtask

  task automatic full_run(input string tag, input int m, input int k, input int n, input int mode);
    int cnt, bcnt;
    model_run(m, k, n);
    run(m, k, n, mode, cnt, bcnt);
    check({tag, "_cycles"}, 64'(cnt), 64'(m*n*(k+3)+1));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(m*n*(k+3)));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sat"}, 64'(sat_flag), 64'(sat_m));
    check_c(m, n);
  endtask

  task automatic load_ident8;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        wr_a(r, c, (r == c) ? 32'd1 : 32'd0);
        wr_b(r, c, 32'(r*8+c));
      end
  endtask

  initial begin
    logic [31:0] v;
    int cnt, bcnt, m, k, n;
    reset = 1'b0; start = 1'b0;
    m_dim_m1 = '0; k_dim_m1 = '0; n_dim_m1 = '0;
    a_wr_din = '0; a_wr_addr = '0; a_wr_en = 1'b0;
    b_wr_din = '0; b_wr_addr = '0; b_wr_en = 1'b0;
    c_rd_addr = '0;
    for (int i = 0; i < MD*MD; i++) begin a_m[i] = '0; b_m[i] = '0; c_m[i] = '0; end
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_dout", 64'(c_rd_dout), 64'd0);
    reset = 1'b1;

    // 8x8x8 identity times ramp
    load_ident8();
    full_run("id8", 8, 8, 8, 0);
    rd_c(3, 5, v);
    check("id8_C35", 64'(v), 64'd29);

    // 3x5x2 small signed case
    for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) wr_a(r, c, 32'(r+c+1));
    for (int r = 0; r < 5; r++) for (int c = 0; c < 2; c++) wr_b(r, c, 32'(c-r));
    full_run("m3k5n2", 3, 5, 2, 0);
    rd_c(0, 0, v); check("m3k5n2_C00", 64'(v), 64'h0FFFFFFD8);
    rd_c(0, 1, v); check("m3k5n2_C01", 64'(v), 64'h0FFFFFFE7);
    rd_c(2, 0, v); check("m3k5n2_C20", 64'(v), 64'h0FFFFFFC4);
    rd_c(2, 1, v); check("m3k5n2_C21", 64'(v), 64'h0FFFFFFDD);

    // 1x1x1 minimum size
    wr_a(0, 0, 32'hFFFFFFF9);
    wr_b(0, 0, 32'd6);
    full_run("one", 1, 1, 1, 0);
    rd_c(0, 0, v); check("one_C00", 64'(v), 64'h0FFFFFFD6);

    // 1x2x1 overflow of the stored width
    wr_a(0, 0, 32'h7FFFFFFF); wr_a(0, 1, 32'h7FFFFFFF);
    wr_b(0, 0, 32'h7FFFFFFF); wr_b(1, 0, 32'h7FFFFFFF);
    full_run("ovf", 1, 2, 1, 0);
    rd_c(0, 0, v);
`ifdef MATMUL_SAT_EN
    check("ovf_C00", 64'(v), 64'h07FFFFFFF);
    check("ovf_sat", 64'(sat_flag), 64'd1);
`else
    check("ovf_C00", 64'(v), 64'h000000002);
    check("ovf_sat", 64'(sat_flag), 64'd0);
`endif

    // randomized dims and data
    for (int t = 0; t < 4; t++) begin
      m = int'($urandom_range(1, 6)); k = int'($urandom_range(1, 6)); n = int'($urandom_range(1, 6));
      for (int r = 0; r < m; r++) for (int c = 0; c < k; c++) wr_a(r, c, $urandom());
      for (int r = 0; r < k; r++) for (int c = 0; c < n; c++) wr_b(r, c, $urandom());
      full_run($sformatf("rnd%0d", t), m, k, n, 0);
    end

    // start and A write during a run are ignored
    load_ident8();
    full_run("ignore", 8, 8, 8, 1);
    full_run("rerun", 8, 8, 8, 0);
    rd_c(0, 1, v); check("rerun_C01", 64'(v), 64'd1);

    // reset mid-run, then a clean run
    model_run(8, 8, 8);
    run(8, 8, 8, 2, cnt, bcnt);
    check("abort_cycle", 64'(cnt), 64'd100);
    @(negedge clock);
    reset = 1'b1;
    full_run("after_rst", 8, 8, 8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
